// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch unit
//            (FSM state, queue entry, instruction size).
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Circular FIFO of fetched {pc, instr} entries with flush; the
//            head is read straight from registered storage.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [31:0]                  push_pc,
    input  logic [31:0]                  push_instr,
    input  logic                         pop,
    output logic [31:0]                  head_pc,
    output logic [31:0]                  head_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t       r_mem [DEPTH];
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;

    // Flush beats any push/pop in the same cycle; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_tail <= r_tail + PW'(1);
            if (pop)  r_head <= r_head + PW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) begin
            r_mem[r_tail] <= '{pc: push_pc, instr: push_instr};
        end
    end

    assign head_pc    = r_mem[r_head].pc;
    assign head_instr = r_mem[r_head].instr;
    assign count      = r_count;
    assign full       = (r_count == CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : PC sequencer and fetch FSM feeding a decode queue, with redirect
//            and sticky misaligned-redirect fault. Optional performance
//            counters are enabled by defining FETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_rdy,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t   r_state;
    fetch_state_t   w_state_nxt;
    logic [31:0]    r_pc;
    logic [31:0]    w_pc_nxt;
    logic           w_push;
    logic           w_pop;
    logic           w_flush;
    logic           w_full;
    logic [CW-1:0]  w_count;

    assign w_pop = if_valid & id_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_flush     = 1'b0;

        case (r_state)
            BOOT:  w_state_nxt = FETCH;
            FETCH: begin
                if (imem_rdy && (!w_full || w_pop)) begin
                    w_push   = 1'b1;
                    w_pc_nxt = r_pc + INSTR_BYTES;
                end
            end
            FAULT:   w_state_nxt = FAULT;
            default: w_state_nxt = BOOT;
        endcase

        // A redirect overrides the sequential fetch; once faulted, redirects are ignored.
        if (redirect_valid && (r_state != FAULT)) begin
            w_flush = 1'b1;
            w_push  = 1'b0;
            if (is_word_aligned(redirect_pc)) begin
                w_pc_nxt = redirect_pc;
            end else begin
                w_pc_nxt    = r_pc;
                w_state_nxt = FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (w_flush),
        .push       (w_push),
        .push_pc    (r_pc),
        .push_instr (imem_instr),
        .pop        (w_pop),
        .head_pc    (if_pc),
        .head_instr (if_instr),
        .count      (w_count),
        .full       (w_full)
    );

    assign imem_addr = r_pc;
    assign if_valid  = (w_count != '0);
    assign fault     = (r_state == FAULT);

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (r_state == FETCH) && (!imem_rdy || (w_full && !w_pop));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push)  r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_stall) r_perf_stall   <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch: queue-based reference model
//            compared every cycle plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          QD     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_rdy;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_instr = instr_of(imem_addr);

    instr_fetch #(
        .RESET_PC (RST_PC),
        .QDEPTH   (QD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .imem_rdy       (imem_rdy),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc    = RST_PC;
    bit          m_boot  = 1'b1;
    bit          m_fault = 1'b0;
    bit          chk_en  = 1'b0;
    int          errors  = 0;
    int          checks  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds what decode should see, in order.
    task automatic model_update();
        if (!rst_n) begin
            m_q.delete();
            m_pc    = RST_PC;
            m_boot  = 1'b1;
            m_fault = 1'b0;
        end else begin
            if (redirect_valid && !m_fault) begin
                m_q.delete();
                if (redirect_pc[1:0] == 2'b00) m_pc = redirect_pc;
                else                           m_fault = 1'b1;
            end else begin
                if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
                if (!m_boot && !m_fault && imem_rdy && m_q.size() < QD) begin
                    m_q.push_back(ent_t'{pc: m_pc, instr: instr_of(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_boot = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_update();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_imem_addr", imem_addr, m_pc);
                chk("m_if_valid", 32'(if_valid), 32'(m_q.size() != 0));
                chk("m_fault", 32'(fault), 32'(m_fault));
                if (m_q.size() != 0) begin
                    chk("m_if_pc", if_pc, m_q[0].pc);
                    chk("m_if_instr", if_instr, m_q[0].instr);
                end
            end
        end
    end

    task automatic set_in(input bit r, input bit rdy, input bit idr, input bit rv, input logic [31:0] rpc);
        rst_n          = r;
        imem_rdy       = rdy;
        id_ready       = idr;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    bit [47:0] rdy_pat = 48'hB36D_F10E_975C;
    bit [47:0] idr_pat = 48'h6ED3_1FA4_C92B;

    initial begin
        // Reset, then streaming with both sides ready
        set_in(0, 1, 1, 0, 32'h0);
        step(2);
        chk_en = 1'b1;
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        set_in(1, 1, 1, 0, 32'h0);
        step(1);
        chk("boot_valid", 32'(if_valid), 32'd0);
        chk("boot_addr", imem_addr, 32'h0);
        step(1);
        chk("first_valid", 32'(if_valid), 32'd1);
        chk("first_pc", if_pc, 32'h0);
        chk("first_instr", if_instr, 32'h5A5A_F0F0);
        step(1);
        chk("stream_pc4", if_pc, 32'h4);
        chk("stream_addr8", imem_addr, 32'h8);
        step(1);
        chk("stream_pc8", if_pc, 32'h8);

        // Decode back-pressure fills the queue
        set_in(0, 1, 1, 0, 32'h0);
        step(1);
        set_in(1, 1, 0, 0, 32'h0);
        step(5);
        chk("full_valid", 32'(if_valid), 32'd1);
        chk("full_head", if_pc, 32'h0);
        chk("full_addr", imem_addr, 32'h8);
        set_in(1, 1, 1, 0, 32'h0);
        step(1);
        chk("drain_head", if_pc, 32'h4);

        // imem wait states 1,0,0,1
        set_in(0, 0, 0, 0, 32'h0);
        step(1);
        set_in(1, 0, 0, 0, 32'h0);
        step(1);
        set_in(1, 1, 0, 0, 32'h0); step(1);
        set_in(1, 0, 0, 0, 32'h0); step(2);
        set_in(1, 1, 0, 0, 32'h0); step(1);
        chk("wait_addr", imem_addr, 32'h8);
        chk("wait_head", if_pc, 32'h0);
        set_in(1, 0, 1, 0, 32'h0);
        step(1);
        chk("wait_pop1", if_pc, 32'h4);
        step(1);
        chk("wait_empty", 32'(if_valid), 32'd0);

        // Redirect while queue holds 8 and 12
        set_in(0, 1, 0, 0, 32'h0);
        step(1);
        set_in(1, 1, 0, 0, 32'h0);
        step(3);
        set_in(1, 1, 1, 0, 32'h0);
        step(2);
        chk("pre_redir_head", if_pc, 32'h8);
        set_in(1, 1, 1, 1, 32'h40);
        step(1);
        chk("redir_flush", 32'(if_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        set_in(1, 1, 1, 0, 32'h0);
        step(1);
        chk("redir_head", if_pc, 32'h40);

        // Misaligned redirect, ignored follow-up, reset recovery
        set_in(1, 1, 1, 1, 32'h42);
        step(1);
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_valid", 32'(if_valid), 32'd0);
        chk("fault_addr", imem_addr, 32'h44);
        set_in(1, 1, 1, 1, 32'h80);
        step(1);
        chk("fault_ignore", imem_addr, 32'h44);
        set_in(1, 1, 1, 0, 32'h0);
        step(3);
        chk("fault_sticky", 32'(fault), 32'd1);
        set_in(0, 1, 1, 1, 32'h80);
        step(1);
        chk("fault_clear", 32'(fault), 32'd0);
        chk("fault_rst_addr", imem_addr, RST_PC);

        // PC wrap at top of address space
        set_in(1, 1, 1, 0, 32'h0);
        step(1);
        set_in(1, 1, 1, 1, 32'hFFFF_FFFC);
        step(1);
        chk("wrap_redir", imem_addr, 32'hFFFF_FFFC);
        set_in(1, 1, 1, 0, 32'h0);
        step(1);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_head", if_pc, 32'hFFFF_FFFC);
        chk("wrap_fault", 32'(fault), 32'd0);
        step(1);
        chk("wrap_next", if_pc, 32'h0);

        // Mixed ready patterns with a mid-stream redirect
        for (int i = 0; i < 48; i++) begin
            set_in(1, rdy_pat[i], idr_pat[i], (i == 20), 32'h100);
            step(1);
        end
        set_in(1, 1, 1, 0, 32'h0);
        step(2);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
